// File: rtl/div_arbiter_pkg.sv
// Shared types and helpers for the divider arbiter.
// Optional feature macro: DIV_ZERO_CHECK_EN.
package div_arbiter_pkg;

  localparam int unsigned StateWidth = 2;

  typedef logic [StateWidth-1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StWait  = 2'd2;
  localparam state_t StResp  = 2'd3;

  // Round-robin successor of the owner, wrapping at num_req.
  function automatic int unsigned rr_next(input int unsigned owner, input int unsigned num_req);
    return (owner + 32'd1 >= num_req) ? 32'd0 : owner + 32'd1;
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Requester-side bus of the divider arbiter: request levels, operands, done/quotient/busy.
interface div_arbiter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] dividend_in;
  logic [NUM_REQ*WIDTH-1:0] divider_in;
  logic [NUM_REQ-1:0]       done;
  logic [WIDTH-1:0]         quotient_out;
  logic                     busy;

  modport master (
    output req, dividend_in, divider_in,
    input  done, quotient_out, busy
  );

  modport slave (
    input  req, dividend_in, divider_in,
    output done, quotient_out, busy
  );
endinterface

// File: rtl/div_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from the pointer, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned OWNER_WIDTH = 1
) (
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [OWNER_WIDTH-1:0] i_ptr,
  output logic [OWNER_WIDTH-1:0] o_grant,
  output logic                   o_valid
);

  logic [OWNER_WIDTH-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = OWNER_WIDTH'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_valid && i_req[w_idx]) begin
        o_valid = 1'b1;
        o_grant = w_idx;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multi-cycle divider between NUM_REQ requesters with round-robin arbitration.
// Optional feature macro: DIV_ZERO_CHECK_EN (short-circuits zero divisors with an error flag).
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned OWNER_WIDTH = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  div_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] o_div_dividend,
  output logic [WIDTH-1:0] o_div_divider,
  output logic             o_div_start,
  input  logic [WIDTH-1:0] i_div_quotient,
  input  logic             i_div_ready
`ifdef DIV_ZERO_CHECK_EN
  ,
  output logic             o_div_zero_err
`endif
);

  state_t                 r_state;
  logic [OWNER_WIDTH-1:0] r_ptr;
  logic [OWNER_WIDTH-1:0] r_owner;
  logic [WIDTH-1:0]       r_dividend;
  logic [WIDTH-1:0]       r_divider;
  logic [WIDTH-1:0]       r_quotient;
  logic                   r_wait_first;
`ifdef DIV_ZERO_CHECK_EN
  logic                   r_zero;
`endif

  logic [OWNER_WIDTH-1:0] w_grant;
  logic                   w_valid;
  logic [WIDTH-1:0]       w_sel_dividend;
  logic [WIDTH-1:0]       w_sel_divider;
  logic [NUM_REQ-1:0]     w_done;

  rr_picker #(
    .NUM_REQ    (NUM_REQ),
    .OWNER_WIDTH(OWNER_WIDTH)
  ) u_picker (
    .i_req  (bus.req),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_valid(w_valid)
  );

  assign w_sel_dividend = bus.dividend_in[32'(w_grant) * WIDTH +: WIDTH];
  assign w_sel_divider  = bus.divider_in[32'(w_grant) * WIDTH +: WIDTH];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_dividend   <= '0;
      r_divider    <= '0;
      r_quotient   <= '0;
      r_wait_first <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      r_zero       <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (w_valid) begin
            r_owner    <= w_grant;
            r_dividend <= w_sel_dividend;
            r_divider  <= w_sel_divider;
`ifdef DIV_ZERO_CHECK_EN
            if (w_sel_divider == '0) begin
              r_quotient <= '1;
              r_zero     <= 1'b1;
              r_state    <= StResp;
            end else begin
              r_zero     <= 1'b0;
              r_state    <= StIssue;
            end
`else
            r_state    <= StIssue;
`endif
          end
        end
        StIssue: begin
          r_wait_first <= 1'b1;
          r_state      <= StWait;
        end
        StWait: begin
          // Ready may still be stale from the previous op during the first WAIT cycle.
          r_wait_first <= 1'b0;
          if (!r_wait_first && i_div_ready) begin
            r_quotient <= i_div_quotient;
            r_state    <= StResp;
          end
        end
        StResp: begin
          r_ptr   <= OWNER_WIDTH'(rr_next(32'(r_owner), NUM_REQ));
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    w_done = '0;
    if (r_state == StResp) begin
      w_done[r_owner] = 1'b1;
    end
  end

  assign bus.done         = w_done;
  assign bus.quotient_out = r_quotient;
  assign bus.busy         = (r_state != StIdle);
  assign o_div_dividend   = r_dividend;
  assign o_div_divider    = r_divider;
  assign o_div_start      = (r_state == StIssue);
`ifdef DIV_ZERO_CHECK_EN
  assign o_div_zero_err   = r_zero && (r_state == StResp);
`endif

endmodule
